// File: rtl/decode_issue.sv
// RV32I decode/issue stage: drives a 1-cycle sync-read register file, tracks RAW hazards in a scoreboard.
// Optional: define DECODE_WB_BYPASS_EN to forward the previous-cycle writeback into READ operands.
module decode_issue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_instr,
  input  logic [XLEN-1:0]          if_pc,
  output logic [$clog2(NREGS)-1:0] rf_r_addr1,
  output logic [$clog2(NREGS)-1:0] rf_r_addr2,
  input  logic [XLEN-1:0]          rf_r_data1,
  input  logic [XLEN-1:0]          rf_r_data2,
  input  logic                     wb_reg_write,
  input  logic [$clog2(NREGS)-1:0] wb_w_addr,
  input  logic [XLEN-1:0]          wb_w_data,
  input  logic                     flush,
  output logic                     ex_valid,
  input  logic                     ex_ready,
  output logic [XLEN-1:0]          ex_pc,
  output logic [XLEN-1:0]          ex_rs1_val,
  output logic [XLEN-1:0]          ex_rs2_val,
  output logic [XLEN-1:0]          ex_imm,
  output logic [$clog2(NREGS)-1:0] ex_rd,
  output logic [6:0]               ex_opcode,
  output logic [2:0]               ex_funct3,
  output logic [6:0]               ex_funct7,
  output logic                     ex_reg_write
);

  localparam int unsigned AW = $clog2(NREGS);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_STALL, S_HOLD} state_t;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_t;

  state_t           state;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  hold1, hold2;
  wb_t              wb_d;
  logic [NREGS-1:0] scoreboard;
  logic [NREGS-1:0] sb_next;

  logic [6:0]      opc;
  logic [AW-1:0]   rs1, rs2, rd;
  logic            use1, use2, dec_wr;
  logic [XLEN-1:0] dec_imm;
  logic            fwd1, fwd2, sb_hit1, sb_hit2, hazard;
  logic [XLEN-1:0] op1, op2, iss_rs1, iss_rs2;
  logic            issue_read, issue_hold, accept;

  assign opc = instr_q[6:0];
  assign rd  = instr_q[11:7];
  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];

  // Operand usage, writeback flag and immediate of the latched instruction
  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    dec_wr  = 1'b0;
    dec_imm = '0;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        use1    = 1'b1;
        dec_wr  = 1'b1;
        dec_imm = {{20{instr_q[31]}}, instr_q[31:20]};
      end
      OPC_STORE: begin
        use1    = 1'b1;
        use2    = 1'b1;
        dec_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      end
      OPC_BRANCH: begin
        use1    = 1'b1;
        use2    = 1'b1;
        dec_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                   instr_q[11:8], 1'b0};
      end
      OPC_OP: begin
        use1   = 1'b1;
        use2   = 1'b1;
        dec_wr = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_wr  = 1'b1;
        dec_imm = {instr_q[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec_wr  = 1'b1;
        dec_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                   instr_q[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // A writeback on the address edge leaves stale rf data; wb_d identifies that case
  always_comb begin
    fwd1    = wb_d.we && (wb_d.addr == rs1) && (rs1 != '0);
    fwd2    = wb_d.we && (wb_d.addr == rs2) && (rs2 != '0);
    op1     = fwd1 ? wb_d.data : rf_r_data1;
    op2     = fwd2 ? wb_d.data : rf_r_data2;
    if (!use1) op1 = '0;
    if (!use2) op2 = '0;
    sb_hit1 = use1 && (rs1 != '0) && scoreboard[rs1];
    sb_hit2 = use2 && (rs2 != '0) && scoreboard[rs2];
`ifdef DECODE_WB_BYPASS_EN
    hazard  = sb_hit1 || sb_hit2;
`else
    hazard  = sb_hit1 || sb_hit2 || (use1 && fwd1) || (use2 && fwd2);
`endif
  end

  // Handshake, rf address mux and scoreboard update
  always_comb begin
    issue_read = (state == S_READ) && !hazard && (!ex_valid || ex_ready) && !flush;
    issue_hold = (state == S_HOLD) && ex_ready && !flush;
    if_ready   = reset && !flush && ((state == S_IDLE) || issue_read);
    accept     = if_ready && if_valid;
    rf_r_addr1 = accept ? if_instr[19:15] : rs1;
    rf_r_addr2 = accept ? if_instr[24:20] : rs2;
    iss_rs1    = (state == S_HOLD) ? hold1 : op1;
    iss_rs2    = (state == S_HOLD) ? hold2 : op2;

    sb_next = scoreboard;
    if (wb_reg_write) sb_next[wb_w_addr] = 1'b0;
    if (flush && ex_valid && !ex_ready && ex_reg_write) sb_next[ex_rd] = 1'b0;
    if ((issue_read || issue_hold) && dec_wr && (rd != '0)) sb_next[rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      instr_q      <= '0;
      pc_q         <= '0;
      hold1        <= '0;
      hold2        <= '0;
      wb_d         <= '0;
      scoreboard   <= '0;
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_rd        <= '0;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7    <= '0;
      ex_reg_write <= 1'b0;
    end else begin
      wb_d       <= {wb_reg_write, wb_w_addr, wb_w_data};
      scoreboard <= sb_next;
      if (flush) begin
        state    <= S_IDLE;
        ex_valid <= 1'b0;
      end else begin
        if (ex_valid && ex_ready) ex_valid <= 1'b0;
        if (issue_read || issue_hold) begin
          ex_valid     <= 1'b1;
          ex_pc        <= pc_q;
          ex_rs1_val   <= iss_rs1;
          ex_rs2_val   <= iss_rs2;
          ex_imm       <= dec_imm;
          ex_rd        <= rd;
          ex_opcode    <= opc;
          ex_funct3    <= instr_q[14:12];
          ex_funct7    <= instr_q[31:25];
          ex_reg_write <= dec_wr;
        end
        if (accept) begin
          instr_q <= if_instr;
          pc_q    <= if_pc;
        end
        case (state)
          S_IDLE:  if (accept) state <= S_READ;
          S_READ: begin
            if (hazard) begin
              state <= S_STALL;
            end else if (issue_read) begin
              state <= accept ? S_READ : S_IDLE;
            end else begin
              hold1 <= op1;
              hold2 <= op2;
              state <= S_HOLD;
            end
          end
          S_STALL: state <= S_READ;
          S_HOLD:  if (issue_hold) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue with a behavioural 1-cycle sync-read register file.
module tb_decode_issue;

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] I_ADD_X2  = 32'h0010_8133;
  localparam logic [31:0] I_ADDI_X3 = 32'h0030_0193;
  localparam logic [31:0] I_ADDI_X4 = 32'h0040_0213;
  localparam logic [31:0] I_LUI_X5  = 32'h1234_52B7;
  localparam logic [31:0] I_BEQ     = 32'hFE00_0EE3;
  localparam logic [31:0] I_ADDI_X6 = 32'h0060_0313;
  localparam logic [31:0] I_ADDI_X8 = 32'h0080_0413;
  localparam logic [31:0] I_ADD_X7  = 32'h0001_03B3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_r_addr1, rf_r_addr2;
  logic [31:0] rf_r_data1 = '0;
  logic [31:0] rf_r_data2 = '0;
  logic        wb_reg_write;
  logic [4:0]  wb_w_addr;
  logic [31:0] wb_w_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;
  logic        ex_reg_write;

  int checks   = 0;
  int failures = 0;

  logic [31:0] regs [32] = '{default: '0};

  decode_issue dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_r_addr1(rf_r_addr1), .rf_r_addr2(rf_r_addr2),
    .rf_r_data1(rf_r_data1), .rf_r_data2(rf_r_data2),
    .wb_reg_write(wb_reg_write), .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data),
    .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_reg_write(ex_reg_write)
  );

  always #5 clk = ~clk;

  // Register file: read-before-write, data one cycle after address
  always @(posedge clk) begin
    rf_r_data1 <= regs[rf_r_addr1];
    rf_r_data2 <= regs[rf_r_addr2];
    if (wb_reg_write && (wb_w_addr != 5'd0)) regs[wb_w_addr] <= wb_w_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    wb_reg_write = 1'b0; wb_w_addr = '0; wb_w_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
    step(); step();
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_if_ready", 32'(if_ready), 32'd0);
    check("rst_ex_imm", ex_imm, 32'd0);
    check("rst_ex_rd", 32'(ex_rd), 32'd0);
    check("rst_sb", dut.scoreboard, 32'd0);
    reset = 1'b1;
    #1 check("idle_if_ready", 32'(if_ready), 32'd1);

    // addi x1 then add x2,x1,x1 back to back
    if_valid = 1'b1; if_instr = I_ADDI_X1; if_pc = 32'h0;
    step();
    if_instr = I_ADD_X2; if_pc = 32'h4;
    #1 check("read_issue_if_ready", 32'(if_ready), 32'd1);
    check("accept_rf_addr1", 32'(rf_r_addr1), 32'd1);
    step();
    if_valid = 1'b0;
    check("addi_valid", 32'(ex_valid), 32'd1);
    check("addi_imm", ex_imm, 32'd5);
    check("addi_rd", 32'(ex_rd), 32'd1);
    check("addi_wr", 32'(ex_reg_write), 32'd1);
    check("addi_pc", ex_pc, 32'h0);
    check("addi_funct3", 32'(ex_funct3), 32'd0);
    check("sb_x1_set", 32'(dut.scoreboard[1]), 32'd1);
    step();
    check("stall_ex_valid", 32'(ex_valid), 32'd0);
    check("stall_if_ready", 32'(if_ready), 32'd0);
    wb_reg_write = 1'b1; wb_w_addr = 5'd1; wb_w_data = 32'd5;
    step();
    wb_reg_write = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    step();
`else
    step();
    check("nobyp_wait1", 32'(ex_valid), 32'd0);
    step();
    check("nobyp_wait2", 32'(ex_valid), 32'd0);
    step();
`endif
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_rd", 32'(ex_rd), 32'd2);
    check("add_rs1", ex_rs1_val, 32'd5);
    check("add_rs2", ex_rs2_val, 32'd5);
    check("add_opcode", 32'(ex_opcode), 32'h33);
    check("add_funct7", 32'(ex_funct7), 32'd0);
    check("add_pc", ex_pc, 32'h4);

    // back-to-back independent addi x3/x4
    if_valid = 1'b1; if_instr = I_ADDI_X3; if_pc = 32'h8;
    step();
    if_instr = I_ADDI_X4; if_pc = 32'hC;
    #1 check("b2b_if_ready", 32'(if_ready), 32'd1);
    step();
    if_valid = 1'b0;
    check("b2b_rd3", 32'(ex_rd), 32'd3);
    check("b2b_valid3", 32'(ex_valid), 32'd1);
    step();
    check("b2b_rd4", 32'(ex_rd), 32'd4);
    check("b2b_imm4", ex_imm, 32'd4);

    // output blocked for four cycles with lui queued behind
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = I_LUI_X5; if_pc = 32'h10;
    step();
    if_valid = 1'b0;
    check("blk1_rd", 32'(ex_rd), 32'd4);
    check("blk1_valid", 32'(ex_valid), 32'd1);
    step();
    check("hold_if_ready", 32'(if_ready), 32'd0);
    check("blk2_rd", 32'(ex_rd), 32'd4);
    step();
    check("blk3_imm", ex_imm, 32'd4);
    check("blk3_if_ready", 32'(if_ready), 32'd0);
    step();
    check("blk4_rd", 32'(ex_rd), 32'd4);
    check("blk4_pc", ex_pc, 32'hC);
    ex_ready = 1'b1;
    step();
    check("lui_valid", 32'(ex_valid), 32'd1);
    check("lui_rd", 32'(ex_rd), 32'd5);
    check("lui_imm", ex_imm, 32'h1234_5000);
    check("lui_pc", ex_pc, 32'h10);

    // beq x0,x0,-4
    if_valid = 1'b1; if_instr = I_BEQ; if_pc = 32'h14;
    step();
    if_valid = 1'b0;
    step();
    check("beq_valid", 32'(ex_valid), 32'd1);
    check("beq_imm", ex_imm, 32'hFFFF_FFFC);
    check("beq_wr", 32'(ex_reg_write), 32'd0);
    check("beq_opcode", 32'(ex_opcode), 32'h63);

    // flush with an unconsumed rd=6 in execute
    if_valid = 1'b1; if_instr = I_ADDI_X6; if_pc = 32'h18;
    step();
    if_valid = 1'b0; ex_ready = 1'b0;
    step();
    check("x6_valid", 32'(ex_valid), 32'd1);
    check("x6_rd", 32'(ex_rd), 32'd6);
    check("x6_sb", dut.scoreboard, 32'h0000_007C);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_sb", dut.scoreboard, 32'h0000_003C);

    // reset in the middle of a STALL
    if_valid = 1'b1; if_instr = I_ADDI_X8; if_pc = 32'h1C;
    step();
    if_instr = I_ADD_X7; if_pc = 32'h20;
    #1 check("x8_if_ready", 32'(if_ready), 32'd1);
    step();
    if_valid = 1'b0;
    check("x8_rd", 32'(ex_rd), 32'd8);
    check("x8_sb", dut.scoreboard, 32'h0000_013C);
    step();
    check("x7_stall_if_ready", 32'(if_ready), 32'd0);
    check("x7_stall_valid", 32'(ex_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_valid", 32'(ex_valid), 32'd0);
    check("midrst_sb", dut.scoreboard, 32'd0);
    check("midrst_rd", 32'(ex_rd), 32'd0);
    check("midrst_if_ready", 32'(if_ready), 32'd0);
    step();
    reset = 1'b1;
    #1 check("post_rst_if_ready", 32'(if_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
